// File: rtl/result_serializer.sv
// Parallel-to-serial converter for the 16-bit result register, feeding the serial display/host link.
// Latency: first bit on sout the cycle after capture; done pulses WIDTH*BIT_CYCLES+1 cycles after capture.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored (nothing queued, no error).
module result_serializer #(
  parameter int WIDTH      = 16,
  parameter int MSB_FIRST  = 1,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  // Counter widths: bit counter indexes 0..WIDTH-1, hold counter 0..BIT_CYCLES-1
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = $clog2(BIT_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Captured frame; the bit on sout always sits at the outgoing end of this register
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;

  logic             capture;
  logic             bit_end;
  logic             frame_end;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // A word is taken only on an IDLE edge; the reset branch covers the rst-low case
  assign capture   = (state == IDLE) && in_valid;
  assign bit_end   = (state == SHIFT) && (hold_cnt == HOLD_LAST);
  assign frame_end = bit_end && (bit_cnt == BIT_LAST);

  // Bit order selection: the outgoing end is the MSB or LSB, zeros fill the vacated end
  assign first_bit     = (MSB_FIRST != 0) ? in[WIDTH-1]    : in[0];
  assign next_bit      = (MSB_FIRST != 0) ? shreg[WIDTH-2] : shreg[1];
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE is always a single cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; in_ready also drops combinationally while rst is low
  always_comb begin
    in_ready = (state == IDLE) && rst;
    busy     = (state == SHIFT) || (state == DONE);
    done     = (state == DONE);
  end

  // Datapath: capture, per-bit hold, shift, and the registered serial outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else if (capture) begin
      shreg      <= in;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      sout       <= first_bit;
      sout_valid <= 1'b1;
    end else if (state == SHIFT) begin
      if (bit_end) begin
        hold_cnt <= '0;
        shreg    <= shreg_shifted;
        if (frame_end) begin
          // Last bit has been held its full time: blank the line for DONE
          bit_cnt    <= '0;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          sout    <= next_bit;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
